rptr_handler_sync: RTL and testbench
====================================

Name: rptr_handler_sync

Overview:
Read-side pointer stage of the asynchronous FIFO, in the read clock domain. It receives the Gray write pointer from the write domain and synchronises it through two flops. It advances the binary and Gray read pointers used for RAM addressing and hands them back to the write domain. It also produces registered empty, occupancy level, almost-empty and a sticky underflow flag.

Parameters:
PTR_WIDTH, 3, RAM address width; pointers carry PTR_WIDTH+1 bits (extra wrap bit); depth = 2**PTR_WIDTH
AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH; legal range 0..2**PTR_WIDTH

Ports:
r_clk  in  1  read-domain clock, all state on rising edge
r_rst_n  in  1  asynchronous, active-low reset
r_en  in  1  read request
g_wptr  in  PTR_WIDTH+1  Gray write pointer, raw from write domain (unsynchronised)
underflow_clr  in  1  clears sticky underflow
b_rptr  out  PTR_WIDTH+1  binary read pointer; RAM read address = b_rptr[PTR_WIDTH-1:0]
g_rptr  out  PTR_WIDTH+1  Gray read pointer, to the write-domain synchroniser
empty  out  1  FIFO empty, registered
level  out  PTR_WIDTH+1  entries available to read, registered
almost_empty  out  1  level <= AE_THRESH, registered
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset: r_rst_n low clears state immediately, without waiting for a clock edge.
  - sync1, sync2, b_rptr, g_rptr = 0; level = 0; underflow = 0; empty = 1; almost_empty = 1.
  - Deassertion is assumed synchronous to r_clk (external reset synchroniser).
- Synchroniser: sync1 <= g_wptr; sync2 <= sync1. g_wptr_sync = sync2. No logic between the two flops.
- Gray to binary: b_wptr_sync[MSB] = g_wptr_sync[MSB]; b[i] = b[i+1] ^ g[i], purely combinational.
- Read accept: rd_ok = r_en & ~empty, using the registered empty.
  - b_rptr_next = b_rptr + rd_ok, modulo 2**(PTR_WIDTH+1).
  - g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next.
  - b_rptr and g_rptr register the next values every cycle.
- Empty: empty <= (g_rptr_next == g_wptr_sync). The full-width compare includes the wrap bit.
- Level: level <= b_wptr_sync - b_rptr_next, modulo 2**(PTR_WIDTH+1). The result is never greater than 2**PTR_WIDTH for legal traffic.
- Almost empty: almost_empty <= (b_wptr_sync - b_rptr_next) <= AE_THRESH. It is computed from the same expression as level, not from the registered level.
- Underflow: underflow <= (r_en & empty) | (underflow & ~underflow_clr). If a set and a clear occur in the same cycle, the set wins.
- Latency:
  - A g_wptr change reaches g_wptr_sync after 2 edges. empty, level and almost_empty reflect it on the 3rd edge.
  - An accepted read updates b_rptr, g_rptr, empty and level on the same edge.
- Read while empty: the pointers hold and underflow sets. RAM data is don't-care.
- Wrap-around:
  - The pointer rolls from 2**(PTR_WIDTH+1)-1 to 0.
  - When both pointers are equal with the wrap bit set, the FIFO is empty. When the low bits match and the wrap bits differ, level = 2**PTR_WIDTH (full).
- Simultaneous write arrival and read: both take effect.
  - empty and level use the already-synchronised write pointer together with the post-read rptr.
  - A write still in flight in the synchroniser is counted conservatively (late), never early.
- Only one Gray bit of g_rptr changes per accepted read.

Decomposition:
- Shared package fifo_pkg holds:
  - PTR_WIDTH default.
  - Pointer type logic [PTR_WIDTH:0].
  - bin2gray / gray2bin functions, reused by wptr_handler.
- One natural sub-module: sync_2ff, a parameterised-width 2-flop synchroniser with async active-low reset. It is instantiated here for g_wptr and on the write side for g_rptr.

Test Plan:
1. Reset and idle: pulse r_rst_n low mid-cycle, with no clock edge -> outputs are reset values immediately (empty=1, almost_empty=1, level=0, b_rptr=0, underflow=0). Then hold g_wptr=0 and r_en=1 -> underflow=1 on the next edge, b_rptr stays 0.
2. Sync latency: with PTR_WIDTH=3 and AE_THRESH=1, drive g_wptr=4'b0010 (binary 3) -> empty stays 1 for 2 edges, then on the 3rd edge empty=0, level=3, almost_empty=0.
3. Drain: after scenario 2, hold r_en=1 for 4 cycles -> b_rptr 1,2,3,3; g_rptr 0001,0011,0010,0010; level 2,1,0,0; almost_empty=1 from level 1. empty=1 on the 3rd-read edge. underflow=1 on the 4th edge.
4. Wrap and full: set g_wptr=4'b1100 (binary 8) with rptr=0 -> level=8, empty=0. Read 8 entries -> b_rptr=1000, g_rptr=1100, empty=1. Advance g_wptr through binary 16 (rolls to 0000) and read all -> b_rptr=0000, empty=1.
5. Simultaneous: level=1, and the write pointer advances to 2 in the same cycle that a read is accepted -> after the read edge level=0 and empty=1. Two edges later level=1, empty=0, with no glitch on g_rptr.
6. Underflow clear race: with underflow=1, assert underflow_clr with r_en=0 -> underflow=0. Assert underflow_clr together with r_en=1 while empty -> underflow stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width, pointer type and
// Gray/binary conversions used by both the read and write pointer handlers.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF = 3;

  typedef logic [PTR_WIDTH_DEF:0] ptr_t;

  // Both conversions operate on a zero-extended 32-bit word, so callers of any
  // pointer width can use them and truncate the result back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_handler_sync_if.sv
// Read-side pointer bundle: request/clear inputs, raw write pointer, and the
// pointers and status flags produced in the read clock domain.
interface rptr_handler_sync_if
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF
);
  logic                 r_en;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 underflow_clr;
  logic [PTR_WIDTH:0]   b_rptr;
  logic [PTR_WIDTH:0]   g_rptr;
  logic                 empty;
  logic [PTR_WIDTH:0]   level;
  logic                 almost_empty;
  logic                 underflow;

  modport master (
    output r_en, g_wptr, underflow_clr,
    input  b_rptr, g_rptr, empty, level, almost_empty, underflow
  );

  modport slave (
    input  r_en, g_wptr, underflow_clr,
    output b_rptr, g_rptr, empty, level, almost_empty, underflow
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop clock-domain-crossing synchroniser for a Gray-coded bus.
// No logic sits between the flops so the metastability window stays clean.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;
endmodule

// File: rtl/rptr_handler_sync.sv
// Read-domain pointer stage of the async FIFO: synchronises the Gray write
// pointer, advances the read pointers and registers empty/level/flags.
module rptr_handler_sync
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int AE_THRESH = 1
) (
  input logic                r_clk,
  input logic                r_rst_n,
  rptr_handler_sync_if.slave bus
);
  typedef logic [PTR_WIDTH:0] rptr_t;

  rptr_t g_wptr_sync;
  rptr_t b_wptr_sync;
  rptr_t fill;
  rptr_t b_rptr_d, b_rptr_q;
  rptr_t g_rptr_d, g_rptr_q;
  rptr_t level_d, level_q;
  logic  empty_d, empty_q;
  logic  almost_empty_d, almost_empty_q;
  logic  underflow_d, underflow_q;
  logic  rd_ok;

  sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_sync_wptr (
    .clk   (r_clk),
    .rst_n (r_rst_n),
    .d     (bus.g_wptr),
    .q     (g_wptr_sync)
  );

  // Status is computed from the post-read pointer so an accepted read and
  // the flags it affects land on the same edge.
  always_comb begin
    b_wptr_sync    = rptr_t'(gray2bin(32'(g_wptr_sync)));
    rd_ok          = bus.r_en & ~empty_q;
    b_rptr_d       = b_rptr_q + rptr_t'(rd_ok);
    g_rptr_d       = rptr_t'(bin2gray(32'(b_rptr_d)));
    fill           = b_wptr_sync - b_rptr_d;
    empty_d        = (g_rptr_d == g_wptr_sync);
    level_d        = fill;
    almost_empty_d = (32'(fill) <= 32'(AE_THRESH));
    underflow_d    = (bus.r_en & empty_q) | (underflow_q & ~bus.underflow_clr);
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      b_rptr_q       <= '0;
      g_rptr_q       <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      b_rptr_q       <= b_rptr_d;
      g_rptr_q       <= g_rptr_d;
      level_q        <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.b_rptr       = b_rptr_q;
  assign bus.g_rptr       = g_rptr_q;
  assign bus.level        = level_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_rptr_handler_sync.sv
// Bench for rptr_handler_sync: an integer occupancy model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rptr_handler_sync;
  localparam int PW  = 3;
  localparam int AE  = 1;
  localparam int MOD = 1 << (PW + 1);

  logic r_clk;
  logic r_rst_n;
  int   checks = 0;
  int   errors = 0;

  rptr_handler_sync_if #(.PTR_WIDTH(PW)) bus ();

  rptr_handler_sync #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .bus     (bus)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_to_int(input int g);
    int b;
    b = g;
    for (int k = 1; k <= PW; k++) b = b ^ (g >> k);
    return b;
  endfunction

  // Model: write count seen two edges late, read count advances on accepted reads.
  int m_s1 = 0, m_s2 = 0, m_rp = 0, m_level = 0;
  bit m_empty = 1'b1, m_ae = 1'b1, m_uf = 1'b0;

  always @(posedge r_clk or negedge r_rst_n) begin
    int wcount;
    if (!r_rst_n) begin
      m_s1 = 0; m_s2 = 0; m_rp = 0; m_level = 0;
      m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    end else begin
      wcount  = gray_to_int(m_s2);
      m_uf    = (bus.r_en && m_empty) || (m_uf && !bus.underflow_clr);
      if (bus.r_en && !m_empty) m_rp = (m_rp + 1) % MOD;
      m_level = (wcount - m_rp + MOD) % MOD;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= AE);
      m_s2    = m_s1;
      m_s1    = int'(bus.g_wptr);
    end
  end

  always @(negedge r_clk) begin
    chk("model_b_rptr", bus.b_rptr, m_rp);
    chk("model_g_rptr", bus.g_rptr, m_rp ^ (m_rp >> 1));
    chk("model_level", bus.level, m_level);
    chk("model_empty", bus.empty, m_empty);
    chk("model_almost_empty", bus.almost_empty, m_ae);
    chk("model_underflow", bus.underflow, m_uf);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  initial begin
    r_rst_n           = 1'b0;
    bus.r_en          = 1'b0;
    bus.g_wptr        = '0;
    bus.underflow_clr = 1'b0;
    cyc(2);
    r_rst_n = 1'b1;

    // Reset values, then read while empty
    chk("rst_empty", bus.empty, 1);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_b_rptr", bus.b_rptr, 0);
    chk("rst_uf", bus.underflow, 0);
    bus.r_en = 1'b1;
    cyc();
    chk("idle_uf_set", bus.underflow, 1);
    chk("idle_b_rptr_hold", bus.b_rptr, 0);
    bus.r_en = 1'b0; bus.underflow_clr = 1'b1;
    cyc();
    chk("uf_clear", bus.underflow, 0);
    bus.underflow_clr = 1'b0;

    // Sync latency: gray 0010 = 3 entries
    bus.g_wptr = 4'b0010;
    cyc();
    chk("lat_edge1_empty", bus.empty, 1);
    cyc();
    chk("lat_edge2_empty", bus.empty, 1);
    cyc();
    chk("lat_edge3_empty", bus.empty, 0);
    chk("lat_edge3_level", bus.level, 3);
    chk("lat_edge3_ae", bus.almost_empty, 0);

    // Drain
    bus.r_en = 1'b1;
    cyc();
    chk("drain1_b", bus.b_rptr, 1); chk("drain1_g", bus.g_rptr, 4'b0001);
    chk("drain1_level", bus.level, 2); chk("drain1_ae", bus.almost_empty, 0);
    cyc();
    chk("drain2_b", bus.b_rptr, 2); chk("drain2_g", bus.g_rptr, 4'b0011);
    chk("drain2_level", bus.level, 1); chk("drain2_ae", bus.almost_empty, 1);
    cyc();
    chk("drain3_b", bus.b_rptr, 3); chk("drain3_g", bus.g_rptr, 4'b0010);
    chk("drain3_level", bus.level, 0); chk("drain3_empty", bus.empty, 1);
    chk("drain3_uf", bus.underflow, 0);
    cyc();
    chk("drain4_b", bus.b_rptr, 3); chk("drain4_uf", bus.underflow, 1);
    bus.underflow_clr = 1'b1;
    cyc();
    chk("uf_set_beats_clr", bus.underflow, 1);
    bus.r_en = 1'b0; bus.underflow_clr = 1'b0;

    // Asynchronous reset pulse between clock edges
    bus.g_wptr = '0;
    @(negedge r_clk);
    #1 r_rst_n = 1'b0;
    #2;
    chk("async_b_rptr", bus.b_rptr, 0);
    chk("async_g_rptr", bus.g_rptr, 0);
    chk("async_uf", bus.underflow, 0);
    chk("async_empty", bus.empty, 1);
    chk("async_ae", bus.almost_empty, 1);
    chk("async_level", bus.level, 0);
    #1 r_rst_n = 1'b1;
    cyc();

    // Full, then drain across the wrap bit
    bus.g_wptr = 4'b1100;
    cyc(3);
    chk("full_level", bus.level, 8);
    chk("full_empty", bus.empty, 0);
    bus.r_en = 1'b1;
    cyc(8);
    bus.r_en = 1'b0;
    chk("wrap1_b", bus.b_rptr, 4'b1000);
    chk("wrap1_g", bus.g_rptr, 4'b1100);
    chk("wrap1_empty", bus.empty, 1);
    for (int k = 9; k <= 16; k++) begin
      bus.g_wptr = 4'((k % MOD) ^ ((k % MOD) >> 1));
      cyc();
    end
    cyc(3);
    chk("wrap2_level", bus.level, 8);
    chk("wrap2_empty", bus.empty, 0);
    bus.r_en = 1'b1;
    cyc(8);
    bus.r_en = 1'b0;
    chk("wrap2_b", bus.b_rptr, 0);
    chk("wrap2_empty_after", bus.empty, 1);

    // Write arrival coinciding with an accepted read
    bus.g_wptr = 4'b0001;
    cyc(3);
    chk("sim_pre_level", bus.level, 1);
    bus.g_wptr = 4'b0011; bus.r_en = 1'b1;
    cyc();
    bus.r_en = 1'b0;
    chk("sim_read_level", bus.level, 0);
    chk("sim_read_empty", bus.empty, 1);
    chk("sim_read_g", bus.g_rptr, 4'b0001);
    cyc();
    chk("sim_mid_level", bus.level, 0);
    cyc();
    chk("sim_late_level", bus.level, 1);
    chk("sim_late_empty", bus.empty, 0);
    chk("sim_late_g", bus.g_rptr, 4'b0001);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
